// File: rtl/dds_sin_gen.sv
// dds_sin_gen: direct-digital-synthesis sine generator.
//
// A PW-bit phase accumulator steps by a runtime frequency word. The top two
// phase bits pick the quadrant, the next AW bits address a quarter-wave
// table, and the quadrant folds the address and restores the sign. The
// magnitude can be attenuated by a right shift before the sign is applied.
// The generator runs continuously, or for a single period in one-shot mode.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   en            start / continue request (level)
//   mode          0 = continuous, 1 = one-shot (single period)
//   freq_word     phase increment per sample (0 is ignored)
//   amp_shift     magnitude attenuation, magnitude >> amp_shift
//   sin_out       signed DW-bit sample, holds while sin_valid is low
//   sin_valid     sin_out carries a new sample
//   busy          high while running or draining
//   done          one-cycle pulse on return to idle
//   period_start  one-cycle pulse with the sample of phase 0
module dds_sin_gen #(
  parameter int PW = 16,
  parameter int AW = 8,
  parameter int DW = 9
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 mode,
  input  logic [PW-1:0]        freq_word,
  input  logic [1:0]           amp_shift,
  output logic signed [DW-1:0] sin_out,
  output logic                 sin_valid,
  output logic                 busy,
  output logic                 done,
  output logic                 period_start
);

  localparam int N    = 1 << AW;
  localparam int AMAX = (1 << (DW - 1)) - 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  // Quarter-wave entry, sampled at the centre of each table step so every
  // entry is non-zero and the folded wave has no repeated zero/peak samples.
  function automatic logic [DW-2:0] tbl_entry(input int i);
    real x;
    int  v;
    x = real'(AMAX) * $sin(3.14159265358979323846 * (real'(i) + 0.5) / (2.0 * real'(N)));
    v = $rtoi(x + 0.5);
    return v[DW-2:0];
  endfunction

  // Attenuate first, then negate: the shifted magnitude always fits in
  // DW-1 bits, so the two's complement negation cannot overflow.
  function automatic logic signed [DW-1:0] shape(input logic [DW-2:0] mag,
                                                 input logic [1:0]    sh,
                                                 input logic          neg);
    logic [DW-2:0]        m;
    logic signed [DW-1:0] s;
    m = mag >> sh;
    s = signed'({1'b0, m});
    return neg ? -s : s;
  endfunction

  logic [DW-2:0] tbl [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_tbl
    assign tbl[gi] = tbl_entry(gi);
  end

  state_t        state_q;
  logic [PW-1:0] phase_q;
  logic [PW-1:0] fw_q;
  logic [1:0]    sh_q;
  logic          os_q;
  logic [1:0]    drain_cnt_q;
  logic          done_q;

  logic [PW:0]   sum;
  logic          wrap;
  logic          issue;
  logic [1:0]    quad;
  logic [AW-1:0] addr;

  assign sum   = {1'b0, phase_q} + {1'b0, fw_q};
  assign wrap  = sum[PW];
  assign issue = (state_q == RUN);
  assign quad  = phase_q[PW-1 -: 2];
  assign addr  = phase_q[PW-3 -: AW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      fw_q        <= '0;
      sh_q        <= '0;
      os_q        <= 1'b0;
      drain_cnt_q <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          phase_q <= '0;
          if (en && (freq_word != '0)) begin
            fw_q    <= freq_word;
            sh_q    <= amp_shift;
            os_q    <= mode;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (wrap && !os_q && en) begin
            // Phase residue carries over; only the settings are reloaded.
            if (freq_word != '0) fw_q <= freq_word;
            sh_q    <= amp_shift;
            os_q    <= mode;
            phase_q <= sum[PW-1:0];
          end else if (wrap) begin
            phase_q     <= '0;
            drain_cnt_q <= '0;
            state_q     <= DRAIN;
          end else begin
            phase_q <= sum[PW-1:0];
          end
        end
        DRAIN: begin
          phase_q <= '0;
          if (drain_cnt_q == 2'd2) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end else begin
            drain_cnt_q <= drain_cnt_q + 2'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Pipeline data: the shift setting travels with each sample so a reload
  // at the wrap never touches samples already in flight.
  logic [AW-1:0] idx_p0;
  logic          neg_p0;
  logic          first_p0;
  logic [1:0]    sh_p0;
  logic [DW-2:0] mag_p1;
  logic          neg_p1;
  logic          first_p1;
  logic [1:0]    sh_p1;

  logic                 vld_p0;
  logic                 vld_p1;
  logic                 vld_p2;
  logic                 first_p2;
  logic signed [DW-1:0] sin_out_p2;

  always_ff @(posedge clk) begin
    // S1: quadrant fold and period-start tag
    idx_p0   <= quad[0] ? ~addr : addr;
    neg_p0   <= quad[1];
    first_p0 <= (phase_q == '0);
    sh_p0    <= sh_q;
    // S2: table read
    mag_p1   <= tbl[idx_p0];
    neg_p1   <= neg_p0;
    first_p1 <= first_p0;
    sh_p1    <= sh_p0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0     <= 1'b0;
      vld_p1     <= 1'b0;
      vld_p2     <= 1'b0;
      first_p2   <= 1'b0;
      sin_out_p2 <= '0;
    end else begin
      vld_p0   <= issue;
      vld_p1   <= vld_p0;
      // S3: attenuate, sign, output register
      vld_p2   <= vld_p1;
      first_p2 <= vld_p1 & first_p1;
      if (vld_p1) sin_out_p2 <= shape(mag_p1, sh_p1, neg_p1);
    end
  end

  assign sin_out      = sin_out_p2;
  assign sin_valid    = vld_p2;
  assign period_start = first_p2;
  assign done         = done_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_dds_sin_gen.sv
module tb_dds_sin_gen;

  localparam int PW = 16;
  localparam int AW = 8;
  localparam int DW = 9;
  localparam int N  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          mode = 1'b0;
  logic [PW-1:0] freq_word = '0;
  logic [1:0]    amp_shift = '0;
  logic [DW-1:0] sin_out;
  logic          sin_valid;
  logic          busy;
  logic          done;
  logic          period_start;

  always #5 clk = ~clk;

  dds_sin_gen #(.PW(PW), .AW(AW), .DW(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .mode         (mode),
    .freq_word    (freq_word),
    .amp_shift    (amp_shift),
    .sin_out      (sin_out),
    .sin_valid    (sin_valid),
    .busy         (busy),
    .done         (done),
    .period_start (period_start)
  );

  typedef struct packed {
    logic [DW-1:0] v;
    logic          ps;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   nsamp = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  int   last_cyc = 0;
  int   tbl_m [N];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] model(input int unsigned ph, input int sh);
    int q, a, idx, m;
    q   = int'((ph >> (PW - 2)) & 3);
    a   = int'((ph >> (PW - 2 - AW)) & (N - 1));
    idx = (q & 1) ? (N - 1 - a) : a;
    m   = tbl_m[idx] >> sh;
    if ((q & 2) != 0) m = -m;
    return m[DW-1:0];
  endfunction

  task automatic push(input logic [DW-1:0] v, input logic ps);
    exp_t e;
    e.v  = v;
    e.ps = ps;
    sbq.push_back(e);
  endtask

  task automatic push_model(input int unsigned fw, input int sh, input int n, input int unsigned ph0);
    int unsigned ph;
    ph = ph0;
    for (int k = 0; k < n; k++) begin
      push(model(ph, sh), ph == 0);
      ph = (ph + fw) & 32'h0000_FFFF;
    end
  endtask

  task automatic start(input logic m, input int unsigned fw, input int sh);
    @(negedge clk);
    mode      = m;
    freq_word = fw[PW-1:0];
    amp_shift = sh[1:0];
    en        = 1'b1;
    nsamp     = 0;
    @(posedge clk);
  endtask

  task automatic wait_done(input string tag, input int exp_n);
    int d0, k;
    d0 = done_cnt;
    k  = 0;
    while (done_cnt == d0 && k < 5000) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_done_seen"}, done_cnt - d0, 1);
    chk({tag, "_nsamp"}, nsamp, exp_n);
    chk({tag, "_sb_empty"}, sbq.size(), 0);
    chk({tag, "_done_after_last"}, done_cyc - last_cyc, 1);
    repeat (3) @(negedge clk);
    chk({tag, "_busy_after"}, busy, 0);
    chk({tag, "_single_done"}, done_cnt - d0, 1);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (sin_valid) begin
        nsamp++;
        last_cyc = cyc;
        if (sbq.size() == 0) begin
          chk("extra_sample", 1, 0);
        end else begin
          mon_e = sbq.pop_front();
          chk("sample", sin_out, mon_e.v);
          chk("period_start", period_start, mon_e.ps);
        end
      end else if (period_start) begin
        chk("ps_without_valid", 1, 0);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("busy_at_done", busy, 0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad, d0;
    for (int i = 0; i < N; i++)
      tbl_m[i] = $rtoi(255.0 * $sin(3.14159265358979323846 * (real'(i) + 0.5) / 512.0) + 0.5);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_sin_out", sin_out, 0);
    chk("rst_valid", sin_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ps", period_start, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // One-shot, quarter-period steps
    push(9'h001, 1'b1);
    push(9'h0FF, 1'b0);
    push(9'h1FF, 1'b0);
    push(9'h101, 1'b0);
    start(1'b1, 16384, 0);
    @(negedge clk);
    chk("t1_busy_rise", busy, 1);
    en = 1'b0;
    wait_done("t1", 4);

    // One-shot, full table sweep
    push_model(64, 0, 1024, 0);
    start(1'b1, 64, 0);
    @(negedge clk);
    en = 1'b0;
    wait_done("t2", 1024);

    // Continuous with attenuation, reload at the first wrap
    push(9'h000, 1'b1);
    push(9'h03F, 1'b0);
    push(9'h000, 1'b0);
    push(9'h1C1, 1'b0);
    push_model(8192, 0, 8, 0);
    start(1'b0, 16384, 2);
    @(negedge clk);
    freq_word = 16'd8192;
    amp_shift = 2'd0;
    repeat (6) @(negedge clk);
    en = 1'b0;
    wait_done("t3", 12);

    // Continuous, en dropped during the second sample
    push_model(16384, 0, 4, 0);
    start(1'b0, 16384, 0);
    @(negedge clk);
    @(negedge clk);
    en = 1'b0;
    wait_done("t4", 4);

    // Zero frequency word is ignored
    d0 = done_cnt;
    @(negedge clk);
    freq_word = '0;
    mode      = 1'b0;
    en        = 1'b1;
    bad       = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy || sin_valid) bad++;
    end
    en = 1'b0;
    chk("t5_idle", bad, 0);
    chk("t5_no_done", done_cnt - d0, 0);

    // Asynchronous reset mid-run
    push_model(16384, 0, 8, 0);
    start(1'b0, 16384, 0);
    repeat (5) @(negedge clk);
    d0 = done_cnt;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    sbq.delete();
    #1;
    chk("t6_sin_out", sin_out, 0);
    chk("t6_valid", sin_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_ps", period_start, 0);
    en = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_no_done", done_cnt - d0, 0);
    push(9'h001, 1'b1);
    push(9'h0FF, 1'b0);
    push(9'h1FF, 1'b0);
    push(9'h101, 1'b0);
    start(1'b1, 16384, 0);
    @(negedge clk);
    en = 1'b0;
    wait_done("t6r", 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
